// File: rtl/calc3_port_engine_if.sv
// Request/response bundle for calc3_port_engine. Vectors are big-endian: index 0 is the MSB.
// A request is valid whenever reqx_cmd is nonzero; there is no ready, so every request is taken.
interface calc3_port_engine_if;
  logic [0:3]  reqx_cmd;
  logic [0:3]  reqx_d1;
  logic [0:3]  reqx_d2;
  logic [0:3]  reqx_r1;
  logic [0:1]  reqx_tag;
  logic [0:31] reqx_data;
  logic [0:1]  outx_tag;
  logic [0:1]  outx_resp;
  logic [0:31] outx_data;

  modport master (
    output reqx_cmd, reqx_d1, reqx_d2, reqx_r1, reqx_tag, reqx_data,
    input  outx_tag, outx_resp, outx_data
  );

  modport slave (
    input  reqx_cmd, reqx_d1, reqx_d2, reqx_r1, reqx_tag, reqx_data,
    output outx_tag, outx_resp, outx_data
  );
endinterface

// File: rtl/calc3_port_engine.sv
// Three-stage register-file calculator (decode/read, execute, writeback) with tag tracking.
// Macro CALC3_SHIFT_EN enables the shl/shr commands; without it they respond as errors.
module calc3_port_engine #(
  parameter logic [31:0] REG_RESET_VAL = 32'h0
) (
  input  logic               clock,
  input  logic               reset,
  calc3_port_engine_if.slave port
);
  localparam logic [0:3] CMD_IDLE  = 4'd0;
  localparam logic [0:3] CMD_ADD   = 4'd1;
  localparam logic [0:3] CMD_SUB   = 4'd2;
  localparam logic [0:3] CMD_STORE = 4'd8;
  localparam logic [0:3] CMD_FETCH = 4'd9;
`ifdef CALC3_SHIFT_EN
  localparam logic [0:3] CMD_SHL   = 4'd5;
  localparam logic [0:3] CMD_SHR   = 4'd6;
`endif
  localparam logic [0:1] RESP_NONE = 2'b00;
  localparam logic [0:1] RESP_OK   = 2'b01;
  localparam logic [0:1] RESP_ERR  = 2'b10;
  localparam logic [0:1] RESP_COLL = 2'b11;

  logic [0:31] regs_q [16];
  logic [0:31] regs_d [16];
  logic [0:3]  inflight_q, inflight_d;

  logic        s1_valid_q, s1_valid_d, s1_coll_q, s1_coll_d;
  logic [0:3]  s1_cmd_q, s1_cmd_d, s1_d1_q, s1_d1_d, s1_d2_q, s1_d2_d, s1_r1_q, s1_r1_d;
  logic [0:1]  s1_tag_q, s1_tag_d;
  logic [0:31] s1_data_q, s1_data_d;

  logic        s2_valid_q, s2_valid_d, s2_coll_q, s2_coll_d;
  logic [0:3]  s2_cmd_q, s2_cmd_d, s2_r1_q, s2_r1_d;
  logic [0:1]  s2_tag_q, s2_tag_d;
  logic [0:31] s2_a_q, s2_a_d, s2_b_q, s2_b_d, s2_data_q, s2_data_d;

  logic        s3_valid_q, s3_valid_d, s3_we_q, s3_we_d;
  logic [0:3]  s3_r1_q, s3_r1_d;
  logic [0:1]  s3_tag_q, s3_tag_d, s3_resp_q, s3_resp_d;
  logic [0:31] s3_wdata_q, s3_wdata_d, s3_odata_q, s3_odata_d;

  logic [0:1]  out_tag_q, out_tag_d, out_resp_q, out_resp_d;
  logic [0:31] out_data_q, out_data_d;

  logic        retire_clear, tag_busy;
  logic [0:31] op_a, op_b;
  logic        ex_we;
  logic [0:1]  ex_resp;
  logic [0:31] ex_wdata, ex_odata;
  logic [0:32] ex_sum;

  // A tag retiring from writeback this edge is free again for the request arriving now.
  always_comb begin
    retire_clear = s3_valid_q && (s3_resp_q != RESP_COLL);
    tag_busy     = inflight_q[port.reqx_tag] &&
                   !(retire_clear && (s3_tag_q == port.reqx_tag));
    s1_valid_d   = (port.reqx_cmd != CMD_IDLE);
    s1_coll_d    = tag_busy;
    s1_cmd_d     = port.reqx_cmd;
    s1_d1_d      = port.reqx_d1;
    s1_d2_d      = port.reqx_d2;
    s1_r1_d      = port.reqx_r1;
    s1_tag_d     = port.reqx_tag;
    s1_data_d    = port.reqx_data;
    inflight_d   = inflight_q;
    if (retire_clear) inflight_d[s3_tag_q] = 1'b0;
    if (s1_valid_d && !tag_busy) inflight_d[port.reqx_tag] = 1'b1;
  end

  // Operand read: the youngest older writer wins (execute, then writeback, then the file).
  always_comb begin
    op_a = regs_q[s1_d1_q];
    op_b = regs_q[s1_d2_q];
    if (s3_valid_q && s3_we_q && (s3_r1_q == s1_d1_q)) op_a = s3_wdata_q;
    if (s3_valid_q && s3_we_q && (s3_r1_q == s1_d2_q)) op_b = s3_wdata_q;
    if (ex_we && (s2_r1_q == s1_d1_q)) op_a = ex_wdata;
    if (ex_we && (s2_r1_q == s1_d2_q)) op_b = ex_wdata;
    s2_valid_d = s1_valid_q;
    s2_coll_d  = s1_coll_q;
    s2_cmd_d   = s1_cmd_q;
    s2_r1_d    = s1_r1_q;
    s2_tag_d   = s1_tag_q;
    s2_a_d     = op_a;
    s2_b_d     = op_b;
    s2_data_d  = s1_data_q;
  end

  always_comb begin
    ex_we    = 1'b0;
    ex_resp  = RESP_ERR;
    ex_wdata = '0;
    ex_odata = '0;
    ex_sum   = {1'b0, s2_a_q} + {1'b0, s2_b_q};
    if (s2_coll_q) begin
      ex_resp = RESP_COLL;
    end else begin
      case (s2_cmd_q)
        CMD_ADD: if (!ex_sum[0]) begin
          ex_we    = 1'b1;
          ex_resp  = RESP_OK;
          ex_wdata = ex_sum[1:32];
          ex_odata = ex_sum[1:32];
        end
        CMD_SUB: if (s2_a_q >= s2_b_q) begin
          ex_we    = 1'b1;
          ex_resp  = RESP_OK;
          ex_wdata = s2_a_q - s2_b_q;
          ex_odata = s2_a_q - s2_b_q;
        end
`ifdef CALC3_SHIFT_EN
        CMD_SHL: begin
          ex_we    = 1'b1;
          ex_resp  = RESP_OK;
          ex_wdata = s2_a_q << s2_b_q[27:31];
          ex_odata = s2_a_q << s2_b_q[27:31];
        end
        CMD_SHR: begin
          ex_we    = 1'b1;
          ex_resp  = RESP_OK;
          ex_wdata = s2_a_q >> s2_b_q[27:31];
          ex_odata = s2_a_q >> s2_b_q[27:31];
        end
`endif
        CMD_STORE: begin
          ex_we    = 1'b1;
          ex_resp  = RESP_OK;
          ex_wdata = s2_data_q;
        end
        CMD_FETCH: begin
          ex_resp  = RESP_OK;
          ex_odata = s2_a_q;
        end
        default: ;
      endcase
    end
    if (!s2_valid_q) begin
      ex_we    = 1'b0;
      ex_resp  = RESP_NONE;
      ex_wdata = '0;
      ex_odata = '0;
    end
  end

  always_comb begin
    s3_valid_d = s2_valid_q;
    s3_we_d    = ex_we;
    s3_r1_d    = s2_r1_q;
    s3_tag_d   = s2_tag_q;
    s3_resp_d  = ex_resp;
    s3_wdata_d = ex_wdata;
    s3_odata_d = ex_odata;
    regs_d     = regs_q;
    if (s3_valid_q && s3_we_q) regs_d[s3_r1_q] = s3_wdata_q;
    out_tag_d  = '0;
    out_resp_d = RESP_NONE;
    out_data_d = '0;
    if (s3_valid_q) begin
      out_tag_d  = s3_tag_q;
      out_resp_d = s3_resp_q;
      out_data_d = s3_odata_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      inflight_q <= '0;
      out_tag_q  <= '0;
      out_resp_q <= RESP_NONE;
      out_data_q <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= REG_RESET_VAL;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      inflight_q <= inflight_d;
      out_tag_q  <= out_tag_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
      regs_q     <= regs_d;
    end
  end

  // Payload flops are qualified by the stage valids, so they need no reset.
  always_ff @(posedge clock) begin
    s1_coll_q  <= s1_coll_d;
    s1_cmd_q   <= s1_cmd_d;
    s1_d1_q    <= s1_d1_d;
    s1_d2_q    <= s1_d2_d;
    s1_r1_q    <= s1_r1_d;
    s1_tag_q   <= s1_tag_d;
    s1_data_q  <= s1_data_d;
    s2_coll_q  <= s2_coll_d;
    s2_cmd_q   <= s2_cmd_d;
    s2_r1_q    <= s2_r1_d;
    s2_tag_q   <= s2_tag_d;
    s2_a_q     <= s2_a_d;
    s2_b_q     <= s2_b_d;
    s2_data_q  <= s2_data_d;
    s3_we_q    <= s3_we_d;
    s3_r1_q    <= s3_r1_d;
    s3_tag_q   <= s3_tag_d;
    s3_resp_q  <= s3_resp_d;
    s3_wdata_q <= s3_wdata_d;
    s3_odata_q <= s3_odata_d;
  end

  assign port.outx_tag  = out_tag_q;
  assign port.outx_resp = out_resp_q;
  assign port.outx_data = out_data_q;
endmodule

// File: tb/tb_calc3_port_engine.sv
// Bench for calc3_port_engine: hand-derived vector table, corner sequences and random traffic
// checked every cycle against a sequential reference model with a due-cycle response queue.
module tb_calc3_port_engine;
  localparam logic [31:0] RST_VAL = 32'h1234_5670;
  localparam int W = 68;
`ifdef CALC3_SHIFT_EN
  localparam bit SH_EN = 1'b1;
`else
  localparam bit SH_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  calc3_port_engine_if bus();
  calc3_port_engine #(.REG_RESET_VAL(RST_VAL)) dut (
    .clock (clock),
    .reset (reset),
    .port  (bus)
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  r1;
    logic [1:0]  tag;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] odata;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0]  mregs [16];
  logic [W-1:0] exp_q [$];   // {due_cycle[31:0], tag[1:0], resp[1:0], data[31:0]}
  vec_t         vecs  [$];
  logic [3:0]   cmd_pool [12];

  function automatic vec_t mk(input logic [3:0] cmd, d1, d2, r1, input logic [1:0] tag,
                              input logic [31:0] data, input logic [1:0] resp,
                              input logic [31:0] odata);
    mk = '{cmd, d1, d2, r1, tag, data, resp, odata};
  endfunction

  // Requests take effect instantly in acceptance order; the response is due 3 edges later.
  task automatic model_accept(input logic [3:0] cmd, d1, d2, r1, input logic [1:0] tag,
                              input logic [31:0] data);
    logic        busy;
    logic [1:0]  resp;
    logic [31:0] a, b, odata;
    longint      s;
    busy = 1'b0;
    foreach (exp_q[i])
      if (int'(exp_q[i][67:36]) > cyc && exp_q[i][35:34] == tag && exp_q[i][33:32] != 2'b11)
        busy = 1'b1;
    a = mregs[d1];
    b = mregs[d2];
    resp = 2'b10;
    odata = 32'h0;
    if (busy) resp = 2'b11;
    else begin
      case (cmd)
        4'd1: begin
          s = longint'(a) + longint'(b);
          if (s <= 64'hFFFF_FFFF) begin odata = a + b; mregs[r1] = odata; resp = 2'b01; end
        end
        4'd2: if (a >= b) begin odata = a - b; mregs[r1] = odata; resp = 2'b01; end
        4'd5: if (SH_EN) begin odata = a << (b % 32); mregs[r1] = odata; resp = 2'b01; end
        4'd6: if (SH_EN) begin odata = a >> (b % 32); mregs[r1] = odata; resp = 2'b01; end
        4'd8: begin mregs[r1] = data; resp = 2'b01; end
        4'd9: begin odata = a; resp = 2'b01; end
        default: ;
      endcase
    end
    exp_q.push_back({32'(cyc + 3), tag, resp, odata});
  endtask

  task automatic sb_check();
    logic [1:0]   et, er;
    logic [31:0]  ed;
    logic [W-1:0] e;
    et = 2'b0; er = 2'b0; ed = 32'h0;
    if (exp_q.size() > 0 && int'(exp_q[0][67:36]) == cyc) begin
      e = exp_q.pop_front();
      et = e[35:34]; er = e[33:32]; ed = e[31:0];
    end
    total++;
    if (bus.outx_tag !== et || bus.outx_resp !== er || bus.outx_data !== ed) begin
      bad++;
      $display("FAIL sb cyc=%0d got tag=%0d resp=%b data=%h want tag=%0d resp=%b data=%h",
               cyc, bus.outx_tag, bus.outx_resp, bus.outx_data, et, er, ed);
    end
  endtask

  task automatic expect_out(input string name, input logic [1:0] tag, input logic [1:0] resp,
                            input logic [31:0] data);
    total++;
    if (bus.outx_tag !== tag || bus.outx_resp !== resp || bus.outx_data !== data) begin
      bad++;
      $display("FAIL %s cyc=%0d got tag=%0d resp=%b data=%h want tag=%0d resp=%b data=%h",
               name, cyc, bus.outx_tag, bus.outx_resp, bus.outx_data, tag, resp, data);
    end
  endtask

  task automatic tick(input logic rst, input logic [3:0] cmd, d1, d2, r1,
                      input logic [1:0] tag, input logic [31:0] data);
    reset = rst;
    bus.reqx_cmd = cmd; bus.reqx_d1 = d1; bus.reqx_d2 = d2; bus.reqx_r1 = r1;
    bus.reqx_tag = tag; bus.reqx_data = data;
    @(posedge clock);
    cyc++;
    if (rst) begin
      for (int i = 0; i < 16; i++) mregs[i] = RST_VAL;
      exp_q.delete();
    end else if (cmd != 4'd0) begin
      model_accept(cmd, d1, d2, r1, tag, data);
    end
    #1;
    sb_check();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 32'h0);
  endtask

  initial begin
    cmd_pool = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd8, 4'd8, 4'd9, 4'd9, 4'd3, 4'd0, 4'd1};
    vecs.push_back(mk(4'd8, 4'd0, 4'd0, 4'd1, 2'd0, 32'hFFFF_FFFF, 2'b01, 32'h0));
    vecs.push_back(mk(4'd8, 4'd0, 4'd0, 4'd2, 2'd1, 32'h1, 2'b01, 32'h0));
    vecs.push_back(mk(4'd1, 4'd1, 4'd2, 4'd4, 2'd2, 32'h0, 2'b10, 32'h0));
    vecs.push_back(mk(4'd9, 4'd4, 4'd0, 4'd0, 2'd3, 32'h0, 2'b01, RST_VAL));
    vecs.push_back(mk(4'd8, 4'd0, 4'd0, 4'd3, 2'd0, 32'hFF, 2'b01, 32'h0));
    vecs.push_back(mk(4'd9, 4'd3, 4'd0, 4'd0, 2'd1, 32'h0, 2'b01, 32'hFF));
    vecs.push_back(mk(4'd1, 4'd3, 4'd2, 4'd10, 2'd2, 32'h0, 2'b01, 32'h100));
    vecs.push_back(mk(4'd2, 4'd2, 4'd3, 4'd11, 2'd3, 32'h0, 2'b10, 32'h0));
    vecs.push_back(mk(4'd2, 4'd3, 4'd3, 4'd11, 2'd0, 32'h0, 2'b01, 32'h0));
    vecs.push_back(mk(4'd9, 4'd11, 4'd0, 4'd0, 2'd1, 32'h0, 2'b01, 32'h0));
    vecs.push_back(mk(4'd8, 4'd0, 4'd0, 4'd7, 2'd2, 32'h8000_0001, 2'b01, 32'h0));
    vecs.push_back(mk(4'd8, 4'd0, 4'd0, 4'd8, 2'd3, 32'h4, 2'b01, 32'h0));
    vecs.push_back(mk(4'd6, 4'd7, 4'd8, 4'd9, 2'd0, 32'h0, SH_EN ? 2'b01 : 2'b10,
                      SH_EN ? 32'h0800_0000 : 32'h0));
    vecs.push_back(mk(4'd8, 4'd0, 4'd0, 4'd12, 2'd1, 32'd32, 2'b01, 32'h0));
    vecs.push_back(mk(4'd5, 4'd7, 4'd12, 4'd13, 2'd2, 32'h0, SH_EN ? 2'b01 : 2'b10,
                      SH_EN ? 32'h8000_0001 : 32'h0));
    vecs.push_back(mk(4'd8, 4'd0, 4'd0, 4'd0, 2'd3, 32'h0, 2'b01, 32'h0));
    vecs.push_back(mk(4'd6, 4'd7, 4'd0, 4'd14, 2'd0, 32'h0, SH_EN ? 2'b01 : 2'b10,
                      SH_EN ? 32'h8000_0001 : 32'h0));
    vecs.push_back(mk(4'd9, 4'd9, 4'd0, 4'd0, 2'd1, 32'h0, 2'b01,
                      SH_EN ? 32'h0800_0000 : RST_VAL));
    vecs.push_back(mk(4'd3, 4'd1, 4'd2, 4'd1, 2'd2, 32'h0, 2'b10, 32'h0));
    vecs.push_back(mk(4'd15, 4'd1, 4'd2, 4'd1, 2'd3, 32'h0, 2'b10, 32'h0));
    vecs.push_back(mk(4'd9, 4'd1, 4'd0, 4'd0, 2'd0, 32'h0, 2'b01, 32'hFFFF_FFFF));
    vecs.push_back(mk(4'd8, 4'd0, 4'd0, 4'd0, 2'd1, 32'h5, 2'b01, 32'h0));
    vecs.push_back(mk(4'd9, 4'd0, 4'd0, 4'd0, 2'd2, 32'h0, 2'b01, 32'h5));
    vecs.push_back(mk(4'd1, 4'd1, 4'd0, 4'd15, 2'd3, 32'h0, 2'b10, 32'h0));
    vecs.push_back(mk(4'd1, 4'd0, 4'd0, 4'd0, 2'd0, 32'h0, 2'b01, 32'hA));

    repeat (3) tick(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 32'h0);
    expect_out("reset_out", 2'd0, 2'b00, 32'h0);

    foreach (vecs[i]) begin
      tick(1'b0, vecs[i].cmd, vecs[i].d1, vecs[i].d2, vecs[i].r1, vecs[i].tag, vecs[i].data);
      idle(3);
      expect_out($sformatf("vec%0d", i), vecs[i].tag, vecs[i].resp, vecs[i].odata);
    end

    // Store then fetch back to back.
    tick(1'b0, 4'd8, 4'd0, 4'd0, 4'd3, 2'd1, 32'hFF);
    tick(1'b0, 4'd9, 4'd3, 4'd0, 4'd0, 2'd2, 32'h0);
    idle(2);
    expect_out("st_fetch_a", 2'd1, 2'b01, 32'h0);
    idle(1);
    expect_out("st_fetch_b", 2'd2, 2'b01, 32'hFF);

    // Dependent chain through both bypass paths.
    tick(1'b0, 4'd8, 4'd0, 4'd0, 4'd1, 2'd0, 32'd5);
    tick(1'b0, 4'd1, 4'd1, 4'd1, 4'd5, 2'd1, 32'h0);
    tick(1'b0, 4'd2, 4'd5, 4'd1, 4'd6, 2'd2, 32'h0);
    idle(2);
    expect_out("dep_add", 2'd1, 2'b01, 32'd10);
    idle(1);
    expect_out("dep_sub", 2'd2, 2'b01, 32'd5);

    // Tag collision leaves the second destination write undone.
    tick(1'b0, 4'd8, 4'd0, 4'd0, 4'd6, 2'd3, 32'h77);
    tick(1'b0, 4'd8, 4'd0, 4'd0, 4'd6, 2'd3, 32'hEE);
    idle(2);
    expect_out("coll_first", 2'd3, 2'b01, 32'h0);
    idle(1);
    expect_out("coll_second", 2'd3, 2'b11, 32'h0);
    tick(1'b0, 4'd9, 4'd6, 4'd0, 4'd0, 2'd0, 32'h0);
    idle(3);
    expect_out("coll_reg", 2'd0, 2'b01, 32'h77);

    // Tag reuse boundary: busy two edges later, free on the edge its response is driven.
    tick(1'b0, 4'd9, 4'd6, 4'd0, 4'd0, 2'd2, 32'h0);
    idle(1);
    tick(1'b0, 4'd9, 4'd6, 4'd0, 4'd0, 2'd2, 32'h0);
    tick(1'b0, 4'd9, 4'd6, 4'd0, 4'd0, 2'd2, 32'h0);
    expect_out("reuse_orig", 2'd2, 2'b01, 32'h77);
    idle(2);
    expect_out("reuse_coll", 2'd2, 2'b11, 32'h0);
    idle(1);
    expect_out("reuse_ok", 2'd2, 2'b01, 32'h77);

    // Same register as both operands and destination, chained back to back.
    tick(1'b0, 4'd8, 4'd0, 4'd0, 4'd10, 2'd0, 32'd7);
    tick(1'b0, 4'd1, 4'd10, 4'd10, 4'd10, 2'd1, 32'h0);
    tick(1'b0, 4'd1, 4'd10, 4'd10, 4'd10, 2'd2, 32'h0);
    tick(1'b0, 4'd9, 4'd10, 4'd0, 4'd0, 2'd3, 32'h0);
    idle(3);
    expect_out("self_chain", 2'd3, 2'b01, 32'd28);

    // Reset with three requests in flight and a request present during reset.
    tick(1'b0, 4'd8, 4'd0, 4'd0, 4'd1, 2'd0, 32'd11);
    tick(1'b0, 4'd8, 4'd0, 4'd0, 4'd2, 2'd1, 32'd22);
    tick(1'b0, 4'd8, 4'd0, 4'd0, 4'd3, 2'd2, 32'd33);
    tick(1'b1, 4'd8, 4'd0, 4'd0, 4'd5, 2'd3, 32'd44);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      expect_out("rst_quiet", 2'd0, 2'b00, 32'h0);
    end
    tick(1'b0, 4'd9, 4'd1, 4'd0, 4'd0, 2'd0, 32'h0);
    tick(1'b0, 4'd9, 4'd2, 4'd0, 4'd0, 2'd1, 32'h0);
    tick(1'b0, 4'd9, 4'd3, 4'd0, 4'd0, 2'd2, 32'h0);
    tick(1'b0, 4'd9, 4'd5, 4'd0, 4'd0, 2'd3, 32'h0);
    expect_out("rst_r1", 2'd0, 2'b01, RST_VAL);
    idle(1);
    expect_out("rst_r2", 2'd1, 2'b01, RST_VAL);
    idle(1);
    expect_out("rst_r3", 2'd2, 2'b01, RST_VAL);
    idle(1);
    expect_out("rst_r5", 2'd3, 2'b01, RST_VAL);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rdata;
      rdata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      tick(($urandom_range(0, 199) == 0), cmd_pool[$urandom_range(0, 11)],
           4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), rdata);
    end
    idle(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
